// File: rtl/synth_pkg.sv
// Shared voice definitions: envelope stage encoding and level range.
package synth_pkg;
    localparam int          ENV_W   = 16;
    localparam logic [15:0] ENV_MAX = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_stage_t;
endpackage

// File: rtl/tick_gen.sv
// Control-rate strobe: one-cycle tick every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);
endmodule

// File: rtl/adsr_env.sv
// Linear ADSR envelope: gate synchroniser/edge detect, stage FSM and
// saturating 16-bit level datapath stepped once per control tick.
module adsr_env
    import synth_pkg::*;
#(
    parameter int CLKSPEED = 50_000_000,
    parameter int TICK_DIV = 50_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] decay_step,
    input  logic [ENV_W-1:0] sustain_lvl,
    input  logic [ENV_W-1:0] release_step,
    output logic [ENV_W-1:0] env,
    output env_stage_t       stage,
    output logic             busy
);
    if (TICK_DIV < 2 || TICK_DIV > CLKSPEED) begin : g_bad_tick_div
        $error("adsr_env: TICK_DIV must be in 2..CLKSPEED");
    end

    function automatic logic [ENV_W-1:0] sat_add(input logic [ENV_W-1:0] a,
                                                 input logic [ENV_W-1:0] b);
        logic [ENV_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ENV_W] ? ENV_MAX : s[ENV_W-1:0];
    endfunction

    function automatic logic [ENV_W-1:0] sat_sub(input logic [ENV_W-1:0] a,
                                                 input logic [ENV_W-1:0] b);
        logic [ENV_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[ENV_W] ? '0 : d[ENV_W-1:0];
    endfunction

    logic tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Gate crossing: two sync flops, then the edge reference flop
    logic gate_sync_p0, gate_sync_p1, gate_prev_p2;
    logic rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_sync_p0 <= 1'b0;
            gate_sync_p1 <= 1'b0;
            gate_prev_p2 <= 1'b0;
        end else begin
            gate_sync_p0 <= gate;
            gate_sync_p1 <= gate_sync_p0;
            gate_prev_p2 <= gate_sync_p1;
        end
    end

    assign rise = gate_sync_p1 & ~gate_prev_p2;
    assign fall = ~gate_sync_p1 & gate_prev_p2;

    env_stage_t       stage_next;
    logic [ENV_W-1:0] env_next;
    logic [ENV_W-1:0] lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= IDLE;
            env   <= '0;
        end else begin
            stage <= stage_next;
            env   <= env_next;
        end
    end

    // Gate edges take priority over a coincident tick; env holds on those cycles
    always_comb begin
        stage_next = stage;
        env_next   = env;
        lvl        = '0;
        if (rise) begin
            stage_next = ATTACK;
        end else if (fall && (stage == ATTACK || stage == DECAY || stage == SUSTAIN)) begin
            stage_next = RELEASE;
        end else if (tick) begin
            unique case (stage)
                IDLE: env_next = '0;
                ATTACK: begin
                    lvl      = (attack_step == '0) ? ENV_MAX : sat_add(env, attack_step);
                    env_next = lvl;
                    if (lvl == ENV_MAX) stage_next = DECAY;
                end
                DECAY: begin
                    lvl = sat_sub(env, decay_step);
                    if (decay_step == '0 || lvl <= sustain_lvl) begin
                        env_next   = sustain_lvl;
                        stage_next = SUSTAIN;
                    end else begin
                        env_next = lvl;
                    end
                end
                SUSTAIN: env_next = sustain_lvl;
                RELEASE: begin
                    lvl      = (release_step == '0) ? '0 : sat_sub(env, release_step);
                    env_next = lvl;
                    if (lvl == '0) stage_next = IDLE;
                end
                default: begin
                    env_next   = '0;
                    stage_next = IDLE;
                end
            endcase
        end
    end

    assign busy = (stage != IDLE);
endmodule
